// File: rtl/shift_serializer.sv
// Parallel-to-serial front end feeding a bidirectional shift register stage.
// Optional even-parity trailer bit is enabled by defining SHIFT_SERIALIZER_PARITY_EN.
module shift_serializer #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_lsb_first,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            ser_data,
    output logic            ser_enable,
    output logic            ser_direction,
    output logic            word_done,
    output logic            busy
);

    localparam int CW = $clog2(SIZE);

    generate
        if (SIZE < 2) begin : g_size_check
            $error("shift_serializer: SIZE must be >= 2");
        end
    endgenerate

`ifdef SHIFT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] shreg;
    logic            accept;

    // A word is consumed only on valid & ready; in_ready is high exactly in IDLE.
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            shreg         <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par           <= 1'b0;
`endif
            in_ready      <= 1'b1;
            ser_data      <= 1'b0;
            ser_enable    <= 1'b0;
            ser_direction <= 1'b0;
            word_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg         <= in_data;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        par           <= ^in_data;
`endif
                        ser_direction <= in_lsb_first;
                        count         <= CW'(SIZE - 1);
                        ser_data      <= in_lsb_first ? in_data[0] : in_data[SIZE-1];
                        ser_enable    <= 1'b1;
                        busy          <= 1'b1;
                        in_ready      <= 1'b0;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count == '0) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        ser_data   <= par;
                        state      <= PARITY;
`else
                        ser_data   <= 1'b0;
                        ser_enable <= 1'b0;
                        busy       <= 1'b0;
                        in_ready   <= 1'b1;
                        word_done  <= 1'b1;
                        state      <= IDLE;
`endif
                    end else begin
                        count <= count - CW'(1);
                        // The buffer shifts toward the emitting end so the next bit is always adjacent.
                        if (ser_direction) begin
                            shreg    <= shreg >> 1;
                            ser_data <= shreg[1];
                        end else begin
                            shreg    <= shreg << 1;
                            ser_data <= shreg[SIZE-2];
                        end
                    end
                end
`ifdef SHIFT_SERIALIZER_PARITY_EN
                PARITY: begin
                    ser_data   <= 1'b0;
                    ser_enable <= 1'b0;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                    word_done  <= 1'b1;
                    state      <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: vector table of words with hand-computed
// serial sequences plus back-to-back, ignored-valid and reset-abort sequences.
module tb_shift_serializer;

    localparam int SIZE = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int DW = SIZE + 1;
`else
    localparam int DW = SIZE;
`endif

    logic            clk;
    logic            reset;
    logic [SIZE-1:0] in_data;
    logic            in_lsb_first;
    logic            in_valid;
    logic            in_ready;
    logic            ser_data;
    logic            ser_enable;
    logic            ser_direction;
    logic            word_done;
    logic            busy;

    int total;
    int bad;

    shift_serializer #(.SIZE(SIZE)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_lsb_first(in_lsb_first),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ser_data(ser_data),
        .ser_enable(ser_enable),
        .ser_direction(ser_direction),
        .word_done(word_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       lsb;
        logic [7:0] bits;   // serial bits in emission order, first bit in [7]
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic lsb);
        in_data      = d;
        in_lsb_first = lsb;
        in_valid     = 1'b1;
    endtask

    // Entered at the negedge of the first serial cycle; returns at the negedge of the word_done cycle.
    task automatic watch_frame(input logic [7:0] d, input logic lsb, input logic [7:0] bits,
                               input logic par, input bit noise);
        logic [DW-1:0] ds;
        logic [DW-1:0] ds_exp;
        ds = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (noise) begin
                in_valid = (i >= 1 && i <= 6);
                in_data  = 8'h55;
            end
            chk("ser_enable", 32'(ser_enable), 32'd1);
            chk("ser_data", 32'(ser_data), 32'(bits[7-i]));
            chk("ser_direction", 32'(ser_direction), 32'(lsb));
            chk("in_ready_busy", {30'd0, in_ready, busy}, 32'b01);
            chk("word_done_early", 32'(word_done), 32'd0);
            if (ser_direction) ds = {ser_data, ds[DW-1:1]};
            else               ds = {ds[DW-2:0], ser_data};
            @(negedge clk);
        end
`ifdef SHIFT_SERIALIZER_PARITY_EN
        chk("parity_enable", 32'(ser_enable), 32'd1);
        chk("parity_bit", 32'(ser_data), 32'(par));
        chk("parity_word_done", 32'(word_done), 32'd0);
        if (ser_direction) ds = {ser_data, ds[DW-1:1]};
        else               ds = {ds[DW-2:0], ser_data};
        ds_exp = lsb ? {par, d} : {d, par};
        @(negedge clk);
`else
        ds_exp = d;
`endif
        chk("word_done", 32'(word_done), 32'd1);
        chk("done_enable", 32'(ser_enable), 32'd0);
        chk("done_data", 32'(ser_data), 32'd0);
        chk("done_ready_busy", {30'd0, in_ready, busy}, 32'b10);
        chk("downstream", 32'(ds), 32'(ds_exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{8'h1E, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h1E, 1'b1, 8'h78, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 8'h01, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{8'hB4, 1'b0, 8'hB4, 1'b0};
        vecs[5] = '{8'hB4, 1'b1, 8'h2D, 1'b0};
        vecs[6] = '{8'h07, 1'b0, 8'h07, 1'b1};
        vecs[7] = '{8'hC1, 1'b1, 8'h83, 1'b1};

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_lsb_first = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_outs", {27'd0, ser_data, ser_enable, ser_direction, word_done, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            offer(vecs[v].data, vecs[v].lsb);
            @(negedge clk);
            in_valid = 1'b0;
            watch_frame(vecs[v].data, vecs[v].lsb, vecs[v].bits, vecs[v].par, 1'b0);
            @(negedge clk);
            chk("idle_after_done", {30'd0, word_done, ser_enable}, 32'd0);
        end

        // Back-to-back: valid held high, second word taken in the word_done cycle.
        offer(8'hFF, 1'b0);
        @(negedge clk);
        in_data = 8'h00;
        watch_frame(8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        watch_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // Valid pulsed while busy must be ignored.
        offer(8'hB4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        watch_frame(8'hB4, 1'b0, 8'hB4, 1'b0, 1'b1);
        @(negedge clk);
        chk("noise_no_accept", {30'd0, ser_enable, busy}, 32'd0);

        // Reset mid-frame aborts the word.
        offer(8'h1E, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_enable", 32'(ser_enable), 32'd0);
        chk("abort_ready_busy", {30'd0, in_ready, busy}, 32'b10);
        chk("abort_dir_done", {30'd0, ser_direction, word_done}, 32'd0);
        offer(8'h1E, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        watch_frame(8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0);
        @(negedge clk);

        // Reset and valid together: word is not accepted.
        reset = 1'b1;
        offer(8'hB4, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rst_valid_idle", {30'd0, ser_enable, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
